// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scancode receiver: FSM states,
// register addresses, STATUS bit layout and the frame acceptance rule.
package ps2_scancode_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    localparam logic REG_STATUS = 1'b0;
    localparam logic REG_DATA   = 1'b1;

    localparam int STAT_READY_BIT     = 0;
    localparam int STAT_OVERFLOW_BIT  = 1;
    localparam int STAT_FRAME_ERR_BIT = 2;
    localparam int STAT_COUNT_LSB     = 4;

    // Falls received after the start bit: 8 data bits, parity, stop.
    localparam logic [3:0] LAST_BIT_INDEX = 4'd9;

    // bits[7:0] data, bits[8] parity, bits[9] stop.
    // A frame is good when stop is high and data+parity has odd parity.
    function automatic logic frame_ok(input logic [9:0] bits);
        return bits[9] && (^bits[8:0]);
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_fifo.sv
// Small synchronous FIFO for received scancodes. A pop on a full FIFO
// frees the slot first, so a simultaneous push is still accepted.
module scancode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises the PS/2 lines, frames and
// checks each byte, queues good scancodes and exposes STATUS/DATA registers.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ps_kbclock,
    input  logic                  ps_kbdata,
    input  logic                  read,
    input  logic                  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  key_ready,
    output logic [7:0]            last_code
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   kb_clk;
    logic                   kb_dat;
    logic                   fall;

    rx_state_t              state;
    rx_state_t              state_next;
    logic [3:0]             bit_cnt;
    logic [10:1]            shift_reg;
    logic [TW-1:0]          idle_cnt;
    logic                   timeout;

    logic                   push_req;
    logic                   pop_req;
    logic                   status_rd;
    logic                   set_ovf;
    logic                   set_ferr;
    logic                   overflow;
    logic                   frame_err;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [7:0]             fifo_dout;
    logic [CW-1:0]          fifo_count;
    logic [4:0]             count_wide;
    logic [7:0]             status_byte;

    assign kb_clk    = clk_sync[SYNC_STAGES-1];
    assign kb_dat    = dat_sync[SYNC_STAGES-1];
    assign fall      = clk_prev && !kb_clk;
    assign timeout   = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign status_rd = read && (rd_addr == REG_STATUS);
    assign pop_req   = read && (rd_addr == REG_DATA);
    assign set_ovf   = push_req && fifo_full && !pop_req;
    assign key_ready = !fifo_empty;

    // Bring the PS/2 lines into the core clock domain; idle-high preset avoids a false fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps_kbclock};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps_kbdata};
            clk_prev <= kb_clk;
        end
    end

    // Receiver state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing: start bit, ten shifted bits, one-cycle acceptance check.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        set_ferr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (!kb_dat) state_next = ST_SHIFT;
                    else         set_ferr   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    if (bit_cnt == LAST_BIT_INDEX) state_next = ST_CHECK;
                end else if (timeout) begin
                    state_next = ST_IDLE;
                    set_ferr   = 1'b1;
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (frame_ok(shift_reg)) push_req = 1'b1;
                else                     set_ferr = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Shift in frame bits LSB first, so stop ends up in bit 10 and data in bits 8:1.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state == ST_IDLE && fall && !kb_dat) begin
            bit_cnt <= '0;
        end else if (state == ST_SHIFT && fall) begin
            shift_reg <= {kb_dat, shift_reg[10:2]};
            bit_cnt   <= bit_cnt + 4'd1;
        end
    end

    // Stall watchdog: restarts on every PS/2 clock fall, only runs mid-frame.
    always_ff @(posedge clock) begin
        if (reset || fall || state != ST_SHIFT) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // Sticky flags, cleared by a STATUS read unless re-raised in that same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (overflow && !status_rd) || set_ovf;
            frame_err <= (frame_err && !status_rd) || set_ferr;
        end
    end

    // Last accepted code is shown even if the FIFO had no room for it.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_code <= '0;
        end else if (push_req) begin
            last_code <= shift_reg[8:1];
        end
    end

    scancode_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop_req),
        .din   (shift_reg[8:1]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Assemble the STATUS view; the 4-bit count field saturates for deep FIFOs.
    always_comb begin
        count_wide                       = 5'(fifo_count);
        status_byte                      = '0;
        status_byte[STAT_READY_BIT]      = !fifo_empty;
        status_byte[STAT_OVERFLOW_BIT]   = overflow;
        status_byte[STAT_FRAME_ERR_BIT]  = frame_err;
        status_byte[STAT_COUNT_LSB +: 4] = count_wide[4] ? 4'hF : count_wide[3:0];
    end

    // Registered read port; holds its value between read strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (read) begin
            if (rd_addr == REG_STATUS) begin
                rd_data <= {{(DATA_WIDTH-8){1'b0}}, status_byte};
            end else if (fifo_empty) begin
                rd_data <= '0;
            end else begin
                rd_data <= {{(DATA_WIDTH-8){1'b0}}, fifo_dout};
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised self-checking bench for ps2_scancode_rx against a queue-based
// model of the keyboard buffer, plus directed frame/error/reset scenarios.
module tb_ps2_scancode_rx;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps_kbclock = 1'b1;
    logic        ps_kbdata = 1'b1;
    logic        read = 1'b0;
    logic        rd_addr = 1'b0;
    logic [63:0] rd_data;
    logic        key_ready;
    logic [7:0]  last_code;

    int checks = 0;
    int passes = 0;

    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;
    bit         model_ferr = 1'b0;
    logic [7:0] model_last = 8'h00;

    ps2_scancode_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (2),
        .DATA_WIDTH     (64)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps_kbclock (ps_kbclock),
        .ps_kbdata  (ps_kbdata),
        .read       (read),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .key_ready  (key_ready),
        .last_code  (last_code)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Keyboard-buffer model: a good frame is stored if there is room, else flagged as overflow.
    function automatic void model_frame(input logic [7:0] code, input bit good);
        if (!good) begin
            model_ferr = 1'b1;
        end else begin
            model_last = code;
            if (model_q.size() < DEPTH) model_q.push_back(code);
            else                        model_ovf = 1'b1;
        end
    endfunction

    function automatic logic [63:0] model_status_read();
        int n;
        logic [63:0] s;
        n = model_q.size();
        s = 64'(n * 16 + (model_ferr ? 4 : 0) + (model_ovf ? 2 : 0) + (n != 0 ? 1 : 0));
        model_ovf  = 1'b0;
        model_ferr = 1'b0;
        return s;
    endfunction

    function automatic logic [63:0] model_data_read();
        if (model_q.size() == 0) return 64'h0;
        return 64'(model_q.pop_front());
    endfunction

    function automatic void model_reset();
        model_q.delete();
        model_ovf  = 1'b0;
        model_ferr = 1'b0;
        model_last = 8'h00;
    endfunction

    // Sends n_falls PS/2 bits of a frame; optionally strobes a DATA read in the CHECK cycle.
    task automatic applyStimulus(input logic [7:0] code, input bit bad_parity, input bit bad_stop,
                                 input int n_falls, input bit strobe_check, output logic [63:0] strobe_val);
        logic [10:0] bits;
        bits       = {~bad_stop, (~(^code)) ^ bad_parity, code, 1'b0};
        strobe_val = 64'h0;
        for (int i = 0; i < n_falls; i++) begin
            @(negedge clock);
            ps_kbdata = bits[i];
            repeat (HALF) @(negedge clock);
            ps_kbclock = 1'b0;
            if (strobe_check && i == 10) begin
                repeat (3) @(posedge clock);
                @(negedge clock);
                read    = 1'b1;
                rd_addr = 1'b1;
                @(negedge clock);
                read       = 1'b0;
                strobe_val = rd_data;
                repeat (HALF - 2) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps_kbclock = 1'b1;
        end
        ps_kbdata = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic read_reg(input logic addr, output logic [63:0] val);
        @(negedge clock);
        read    = 1'b1;
        rd_addr = addr;
        @(negedge clock);
        read = 1'b0;
        val  = rd_data;
    endtask

    task automatic check_status(input string tag);
        logic [63:0] v;
        read_reg(1'b0, v);
        checkOutput(tag, v, model_status_read());
    endtask

    task automatic check_data(input string tag);
        logic [63:0] v;
        read_reg(1'b1, v);
        checkOutput(tag, v, model_data_read());
    endtask

    task automatic send_good(input logic [7:0] code);
        logic [63:0] dummy;
        applyStimulus(code, 1'b0, 1'b0, 11, 1'b0, dummy);
        model_frame(code, 1'b1);
    endtask

    initial begin
        logic [63:0] v;
        logic [7:0]  code;
        int          kind;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        checkOutput("reset_rd_data", rd_data, 64'h0);
        checkOutput("reset_key_ready", 64'(key_ready), 64'h0);
        checkOutput("reset_last_code", 64'(last_code), 64'h0);

        // T1: good frame 0x1C
        send_good(8'h1C);
        checkOutput("t1_key_ready", 64'(key_ready), 64'h1);
        checkOutput("t1_last_code", 64'(last_code), 64'h1C);
        check_status("t1_status");
        check_data("t1_data");
        checkOutput("t1_key_ready_after", 64'(key_ready), 64'h0);
        repeat (4) @(negedge clock);
        checkOutput("t1_rd_hold", rd_data, 64'h1C);

        // T2: parity error, flag clears on read
        applyStimulus(8'h1C, 1'b1, 1'b0, 11, 1'b0, v);
        model_frame(8'h1C, 1'b0);
        checkOutput("t2_key_ready", 64'(key_ready), 64'h0);
        check_status("t2_status");
        check_status("t2_status_again");

        // Stray fall with data high while idle
        @(negedge clock);
        ps_kbclock = 1'b0;
        repeat (HALF) @(negedge clock);
        ps_kbclock = 1'b1;
        repeat (HALF) @(negedge clock);
        model_ferr = 1'b1;
        check_status("bad_start_status");

        // Stop bit low
        applyStimulus(8'h33, 1'b0, 1'b1, 11, 1'b0, v);
        model_frame(8'h33, 1'b0);
        check_status("bad_stop_status");

        // T3: overflow with nine frames
        for (int i = 1; i <= 9; i++) send_good(8'(i));
        checkOutput("t3_last_code", 64'(last_code), 64'h09);
        check_status("t3_status");
        for (int i = 0; i < 9; i++) check_data($sformatf("t3_data%0d", i));
        check_status("t3_status_empty");

        // T4: stall mid-frame, then a clean frame
        applyStimulus(8'hAA, 1'b0, 1'b0, 6, 1'b0, v);
        repeat (TIMEOUT + 20) @(negedge clock);
        model_ferr = 1'b1;
        check_status("t4_status");
        send_good(8'hF0);
        check_data("t4_data");

        // T5: DATA read coinciding with the CHECK push
        send_good(8'h21);
        applyStimulus(8'h42, 1'b0, 1'b0, 11, 1'b1, v);
        checkOutput("t5_strobe_data", v, model_data_read());
        model_frame(8'h42, 1'b1);
        check_status("t5_status");
        check_data("t5_data_new");

        // T6: reset mid-frame flushes and the next frame is clean
        send_good(8'h77);
        applyStimulus(8'h99, 1'b0, 1'b0, 4, 1'b0, v);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        checkOutput("t6_key_ready", 64'(key_ready), 64'h0);
        checkOutput("t6_last_code", 64'(last_code), 64'h0);
        check_status("t6_status");
        send_good(8'h5A);
        checkOutput("t6_last_code_after", 64'(last_code), 64'h5A);
        check_data("t6_data");

        // Randomised frames and reads
        for (int n = 0; n < 40; n++) begin
            code = 8'($urandom);
            kind = $urandom_range(0, 5);
            applyStimulus(code, kind == 0, kind == 1, 11, 1'b0, v);
            model_frame(code, kind > 1);
            checkOutput("rnd_last_code", 64'(last_code), 64'(model_last));
            checkOutput("rnd_key_ready", 64'(key_ready), 64'(model_q.size() != 0));
            for (int r = $urandom_range(0, 2); r > 0; r--) begin
                if ($urandom_range(0, 2) == 0) check_status("rnd_status");
                else                           check_data("rnd_data");
            end
        end
        check_status("rnd_final_status");
        while (model_q.size() != 0) check_data("rnd_drain");
        check_data("rnd_empty_data");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
